// File: rtl/multibank_pingpong_buffer_if.sv
// Bus bundle for the N-bank ping-pong buffer: control, write stream and merged read stream.
// master = acquisition/processor side, slave = the buffer itself.
interface multibank_pingpong_buffer_if #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int N_BANKS = 2
);
  localparam int BI_W = $clog2(N_BANKS);

  logic              start;
  logic              stop;
  logic [ADDR_W:0]   block_len;
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              dout_last;
  logic              bank_done;
  logic              done;
  logic              overflow;
  logic [15:0]       drop_count;
  logic [BI_W:0]     banks_ready;
  logic [1:0]        state_out;

  modport master (
    output start, stop, block_len, din, din_valid, dout_ready,
    input  dout, dout_valid, dout_last, bank_done, done, overflow, drop_count,
           banks_ready, state_out
  );

  modport slave (
    input  start, stop, block_len, din, din_valid, dout_ready,
    output dout, dout_valid, dout_last, bank_done, done, overflow, drop_count,
           banks_ready, state_out
  );
endinterface

// File: rtl/multibank_pingpong_buffer.sv
// N-bank ping-pong buffer: one bank fills from the acquisition stream while completed
// banks drain in fill order through a synchronous-read memory and a 2-entry output skid.
module multibank_pingpong_buffer #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int N_BANKS = 2
) (
  input logic                          clock,
  input logic                          reset,
  multibank_pingpong_buffer_if.slave   bus
);
  localparam int BI_W  = $clog2(N_BANKS);
  localparam int MEM_W = BI_W + ADDR_W;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FLUSH = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [BI_W-1:0]   wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [N_BANKS-1:0] full_q, full_d;
  logic [ADDR_W:0]   blen_q [N_BANKS];
  logic [ADDR_W:0]   blen_d [N_BANKS];
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_q, drop_d;
  logic              bank_done_q, bank_done_d, done_q, done_d;

  logic [DATA_W-1:0] mem [0:(1<<MEM_W)-1];
  logic [DATA_W-1:0] rdata_p1_q;
  logic              vld_p1_q, last_p1_q;
  logic [DATA_W-1:0] sk_data_q [2];
  logic [DATA_W-1:0] sk_data_d [2];
  logic [1:0]        sk_last_q, sk_last_d, sk_cnt_q, sk_cnt_d, cnt_after;

  logic              run, rd_active, wr_en, drop, wr_last, part_fill, fill;
  logic [ADDR_W:0]   part_len, fill_len;
  logic              pop, fetch, fetch_last;
  logic [2:0]        inflight;
  logic [BI_W:0]     ready_cnt;

  function automatic logic [BI_W-1:0] bank_inc(input logic [BI_W-1:0] b);
    return (b == BI_W'(N_BANKS - 1)) ? '0 : b + 1'b1;
  endfunction

  assign run       = (state_q == S_RUN);
  assign rd_active = (state_q != S_IDLE);
  assign wr_en     = run && bus.din_valid && !full_q[wr_bank_q];
  assign drop      = run && bus.din_valid &&  full_q[wr_bank_q];
  assign wr_last   = wr_en && ({1'b0, wr_addr_q} == len_q - 1'b1);
  assign part_len  = {1'b0, wr_addr_q} + {{ADDR_W{1'b0}}, wr_en};
  assign part_fill = run && bus.stop && !wr_last && (part_len != '0);
  assign fill      = wr_last || part_fill;
  assign fill_len  = wr_last ? len_q : part_len;

  // Stalled output only prefetches into an empty pipe, so a stalled bank is not drained early.
  assign pop        = (sk_cnt_q != 2'd0) && bus.dout_ready;
  assign inflight   = {1'b0, sk_cnt_q} + {2'b00, vld_p1_q};
  assign fetch      = rd_active && full_q[rd_bank_q] &&
                      ((inflight == 3'd0) ||
                       (bus.dout_ready && ((inflight - {2'b00, pop}) < 3'd2)));
  assign fetch_last = fetch && ({1'b0, rd_addr_q} == blen_q[rd_bank_q] - 1'b1);

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_addr_d   = wr_addr_q;
    rd_addr_d   = rd_addr_q;
    full_d      = full_q;
    blen_d      = blen_q;
    overflow_d  = overflow_q;
    drop_d      = drop_q;
    bank_done_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        len_d      = ((bus.block_len == '0) || (bus.block_len > DEPTH)) ? DEPTH : bus.block_len;
        wr_bank_d  = '0;
        rd_bank_d  = '0;
        wr_addr_d  = '0;
        rd_addr_d  = '0;
        overflow_d = 1'b0;
        drop_d     = '0;
        state_d    = S_RUN;
      end
      S_RUN: if (bus.stop) state_d = S_FLUSH;
      S_FLUSH: if ((full_q == '0) && (sk_cnt_q == 2'd0) && !vld_p1_q) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (wr_en) wr_addr_d = wr_addr_q + 1'b1;
    if (fill) begin
      full_d[wr_bank_q] = 1'b1;
      blen_d[wr_bank_q] = fill_len;
      wr_bank_d         = bank_inc(wr_bank_q);
      wr_addr_d         = '0;
      bank_done_d       = 1'b1;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
    if (fetch) rd_addr_d = rd_addr_q + 1'b1;
    if (fetch_last) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = bank_inc(rd_bank_q);
      rd_addr_d         = '0;
    end
  end

  // Output skid: entry 0 is dout; a fetched word lands behind whatever survives this pop.
  always_comb begin
    sk_data_d = sk_data_q;
    sk_last_d = sk_last_q;
    cnt_after = sk_cnt_q - {1'b0, pop};
    if (pop) begin
      sk_data_d[0] = sk_data_q[1];
      sk_last_d[0] = sk_last_q[1];
    end
    if (vld_p1_q) begin
      sk_data_d[cnt_after[0]] = rdata_p1_q;
      sk_last_d[cnt_after[0]] = last_p1_q;
    end
    sk_cnt_d = cnt_after + {1'b0, vld_p1_q};
  end

  always_comb begin
    ready_cnt = '0;
    for (int i = 0; i < N_BANKS; i++) ready_cnt = ready_cnt + {{BI_W{1'b0}}, full_q[i]};
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[{wr_bank_q, wr_addr_q}] <= bus.din;
    if (fetch) rdata_p1_q <= mem[{rd_bank_q, rd_addr_q}];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      wr_bank_q   <= '0;
      rd_bank_q   <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      full_q      <= '0;
      blen_q      <= '{default: '0};
      overflow_q  <= 1'b0;
      drop_q      <= '0;
      bank_done_q <= 1'b0;
      done_q      <= 1'b0;
      vld_p1_q    <= 1'b0;
      last_p1_q   <= 1'b0;
      sk_data_q   <= '{default: '0};
      sk_last_q   <= '0;
      sk_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_addr_q   <= wr_addr_d;
      rd_addr_q   <= rd_addr_d;
      full_q      <= full_d;
      blen_q      <= blen_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
      bank_done_q <= bank_done_d;
      done_q      <= done_d;
      vld_p1_q    <= fetch;
      last_p1_q   <= fetch_last;
      sk_data_q   <= sk_data_d;
      sk_last_q   <= sk_last_d;
      sk_cnt_q    <= sk_cnt_d;
    end
  end

  assign bus.dout        = sk_data_q[0];
  assign bus.dout_valid  = (sk_cnt_q != 2'd0);
  assign bus.dout_last   = sk_last_q[0];
  assign bus.bank_done   = bank_done_q;
  assign bus.done        = done_q;
  assign bus.overflow    = overflow_q;
  assign bus.drop_count  = drop_q;
  assign bus.banks_ready = ready_cnt;
  assign bus.state_out   = state_q;
endmodule

// File: tb/tb_multibank_pingpong_buffer.sv
// Directed bench for the ping-pong buffer: 2-bank and 4-bank instances, output words
// checked against a queue of expected {last, data} filled as samples are driven.
module tb_multibank_pingpong_buffer;
  localparam int DW = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multibank_pingpong_buffer_if #(.DATA_W(DW), .ADDR_W(AW), .N_BANKS(2)) bus2 ();
  multibank_pingpong_buffer_if #(.DATA_W(DW), .ADDR_W(AW), .N_BANKS(4)) bus4 ();

  multibank_pingpong_buffer #(.DATA_W(DW), .ADDR_W(AW), .N_BANKS(2)) dut2 (
    .clock(clk), .reset(rst), .bus(bus2));
  multibank_pingpong_buffer #(.DATA_W(DW), .ADDR_W(AW), .N_BANKS(4)) dut4 (
    .clock(clk), .reset(rst), .bus(bus4));

  int vec = 0, miscmp = 0, cyc = 0;
  int bd2 = 0, done2 = 0, first_vld = -1, wr4_cyc = 0;
  logic [DW:0]   q2[$], q4[$];
  logic [DW:0]   e2, e4;
  logic [DW-1:0] prev_dout4 = '0;
  logic          prev_stall4 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus2.bank_done) bd2++;
    if (bus2.done) done2++;
    if (bus2.dout_valid && first_vld < 0) first_vld = cyc;
    if (bus2.dout_valid && bus2.dout_ready) begin
      if (q2.size() == 0) chk("dout2_extra_word", {15'd0, bus2.dout_last, bus2.dout}, 32'hDEAD_BEEF);
      else begin
        e2 = q2.pop_front();
        chk("dout2_word", {15'd0, bus2.dout_last, bus2.dout}, {15'd0, e2});
      end
    end
  end

  always @(negedge clk) begin
    if (prev_stall4) chk("dout4_hold", {16'd0, bus4.dout}, {16'd0, prev_dout4});
    prev_stall4 = bus4.dout_valid && !bus4.dout_ready;
    prev_dout4  = bus4.dout;
    if (bus4.dout_valid && bus4.dout_ready) begin
      if (q4.size() == 0) chk("dout4_extra_word", {15'd0, bus4.dout_last, bus4.dout}, 32'hDEAD_BEEF);
      else begin
        e4 = q4.pop_front();
        chk("dout4_word", {15'd0, bus4.dout_last, bus4.dout}, {15'd0, e4});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start2(input int len);
    bus2.block_len = len[AW:0];
    bus2.start = 1'b1;
    tick();
    bus2.start = 1'b0;
  endtask

  // Drive n samples first..first+n-1; the first acc are expected back.
  task automatic send2(input int first, input int n, input int acc, input int elen, input bit partial);
    bit lb;
    for (int i = 0; i < n; i++) begin
      bus2.din = DW'(first + i);
      bus2.din_valid = 1'b1;
      lb = ((i % elen) == elen - 1) || (partial && i == acc - 1);
      if (i < acc) q2.push_back({lb, DW'(first + i)});
      if (i == elen - 1) wr4_cyc = cyc;
      tick();
    end
    bus2.din_valid = 1'b0;
  endtask

  task automatic drain2(input string tag);
    int k = 0;
    while ((q2.size() != 0 || bus2.dout_valid) && k < 200) begin tick(); k++; end
    chk(tag, (k < 200), 1);
  endtask

  task automatic finish2(input string tag);
    int k = 0;
    int d0;
    d0 = done2;
    bus2.stop = 1'b1;
    tick();
    bus2.stop = 1'b0;
    while (bus2.state_out != 2'd0 && k < 200) begin tick(); k++; end
    chk({tag, "_to_idle"}, (k < 200), 1);
    tick();
    chk({tag, "_done_pulses"}, done2 - d0, 1);
    chk({tag, "_state_idle"}, bus2.state_out, 0);
  endtask

  initial begin
    int k;
    bus2.start = 0; bus2.stop = 0; bus2.block_len = '0; bus2.din = '0; bus2.din_valid = 0; bus2.dout_ready = 0;
    bus4.start = 0; bus4.stop = 0; bus4.block_len = '0; bus4.din = '0; bus4.din_valid = 0; bus4.dout_ready = 0;
    repeat (3) tick();
    chk("rst_dout", bus2.dout, 0);
    chk("rst_dout_valid", bus2.dout_valid, 0);
    chk("rst_dout_last", bus2.dout_last, 0);
    chk("rst_bank_done", bus2.bank_done, 0);
    chk("rst_done", bus2.done, 0);
    chk("rst_overflow", bus2.overflow, 0);
    chk("rst_drop_count", bus2.drop_count, 0);
    chk("rst_banks_ready", bus2.banks_ready, 0);
    chk("rst_state", bus2.state_out, 0);
    chk("rst_state4", bus4.state_out, 0);
    rst = 1'b0;
    tick();

    // Two full banks of 4 with the consumer always ready.
    first_vld = -1; bd2 = 0;
    start2(4);
    chk("s1_state_run", bus2.state_out, 1);
    bus2.dout_ready = 1'b1;
    send2(1, 8, 8, 4, 0);
    drain2("s1_drain");
    chk("s1_bank_done_count", bd2, 2);
    chk("s1_first_latency", first_vld - wr4_cyc, 3);
    chk("s1_overflow", bus2.overflow, 0);
    chk("s1_banks_ready", bus2.banks_ready, 0);
    finish2("s1");

    // Consumer stalled: both banks fill, the last 4 samples are dropped.
    bus2.dout_ready = 1'b0;
    start2(4);
    send2(1, 12, 8, 4, 0);
    tick();
    chk("s2_overflow", bus2.overflow, 1);
    chk("s2_drop_count", bus2.drop_count, 4);
    chk("s2_banks_ready", bus2.banks_ready, 2);
    bus2.dout_ready = 1'b1;
    drain2("s2_drain");
    chk("s2_overflow_sticky", bus2.overflow, 1);
    finish2("s2");

    // block_len 0 and block_len 9 both mean a full 8-word bank.
    start2(0);
    send2(1, 8, 8, 8, 0);
    drain2("s3_drain_len0");
    finish2("s3a");
    start2(9);
    send2(21, 8, 8, 8, 0);
    drain2("s3_drain_len9");
    finish2("s3b");

    // Stop after 6 words: partial second bank of 2 is flushed.
    bd2 = 0;
    start2(4);
    send2(1, 6, 6, 4, 1);
    finish2("s4");
    chk("s4_bank_done_count", bd2, 2);
    chk("s4_queue_empty", q2.size(), 0);

    // Four banks of 2, stalled until all are full, then a toggling consumer.
    bus4.block_len = 4'd2;
    bus4.start = 1'b1;
    tick();
    bus4.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus4.din = DW'(i + 1);
      bus4.din_valid = 1'b1;
      q4.push_back({(i % 2) == 1, DW'(i + 1)});
      tick();
    end
    bus4.din_valid = 1'b0;
    repeat (3) tick();
    chk("s5_banks_ready4", bus4.banks_ready, 4);
    chk("s5_drop_count4", bus4.drop_count, 0);
    k = 0;
    while ((q4.size() != 0 || bus4.dout_valid) && k < 200) begin
      bus4.dout_ready = (k % 2) == 1;
      tick();
      k++;
    end
    chk("s5_drain4", (k < 200), 1);
    bus4.dout_ready = 1'b0;
    bus4.stop = 1'b1;
    tick();
    bus4.stop = 1'b0;
    k = 0;
    while (bus4.state_out != 2'd0 && k < 50) begin tick(); k++; end
    chk("s5_idle4", bus4.state_out, 0);

    // Asynchronous reset in the middle of a run discards everything.
    bus2.dout_ready = 1'b0;
    start2(4);
    send2(1, 4, 4, 4, 0);
    repeat (2) tick();
    chk("s6_banks_ready_pre", bus2.banks_ready, 1);
    chk("s6_dout_valid_pre", bus2.dout_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("s6_rst_dout", bus2.dout, 0);
    chk("s6_rst_dout_valid", bus2.dout_valid, 0);
    chk("s6_rst_banks_ready", bus2.banks_ready, 0);
    chk("s6_rst_state", bus2.state_out, 0);
    chk("s6_rst_bank_done", bus2.bank_done, 0);
    q2.delete();
    tick();
    rst = 1'b0;
    tick();
    start2(4);
    chk("s6_restart_overflow", bus2.overflow, 0);
    chk("s6_restart_state", bus2.state_out, 1);
    bus2.dout_ready = 1'b1;
    send2(41, 4, 4, 4, 0);
    drain2("s6_drain");
    finish2("s6");

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
